skein_nonce_sched: RTL

- Sequencer and result filter wrapped around the skein512 pipeline.
- Accepts one mining job over a valid/ready handshake and streams an inclusive nonce range into the core, one nonce per issue slot.
- Tracks each issued nonce through a tag shift register matched to the core latency, and compares the returned hash against a 64-bit target.
- Pushes winning nonces into a small result FIFO for the host-side collector.

---
 rtl/skein_sched_pkg.sv | 23 ++
 rtl/skein_result_fifo.sv | 49 ++++
 rtl/skein_nonce_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/skein_sched_pkg.sv
// Shared definitions for the skein512 nonce scheduler.
//   CORE_LATENCY_DEF : default hash core latency in cycles
//   HASH_HI_MSB/LSB  : hash word compared against the job target
//   sched_state_e    : scheduler FSM states
//   res_rec_t        : result FIFO entry {nonce, hash_hi}
package skein_sched_pkg;

    localparam int CORE_LATENCY_DEF = 186;
    localparam int HASH_HI_MSB      = 511;
    localparam int HASH_HI_LSB      = 448;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [31:0] nonce;
        logic [63:0] hash_hi;
    } res_rec_t;

endpackage

// File: rtl/skein_result_fifo.sv
// First-word fall-through result FIFO.
//   clk, rst_n  : clock, async active-low reset (pointers only)
//   push, din   : write request and data; ignored while full unless popping
//   pop         : consume head; ignored while empty
//   dout        : head entry, valid whenever empty is low
//   full, empty : occupancy flags
module skein_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/skein_nonce_sched.sv
// Nonce sequencer and result filter around the skein512 pipeline.
//   job_*              : job offer (valid/ready), latched on acceptance
//   abort              : kill the running job, keep stored results
//   core_*             : job fields and current nonce to the core; hash back
//   busy, done         : not idle; one-cycle pulse on normal completion
//   res_*              : FWFT result FIFO head with valid/ready pop
//   overflow(_clr)     : sticky dropped-match flag and its clear
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | job_ready high, waiting for a job
// ST_RUN   | issuing nonces start..end, each held ISSUE_INTERVAL cycles
// ST_DRAIN | nothing issued, waiting for in-flight hashes to return
module skein_nonce_sched
    import skein_sched_pkg::*;
#(
    parameter int CORE_LATENCY   = CORE_LATENCY_DEF,
    parameter int ISSUE_INTERVAL = 2,
    parameter int RES_DEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [511:0] job_midstate,
    input  logic [95:0]  job_data,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic [63:0]  job_target,
    input  logic         abort,
    output logic [511:0] core_midstate,
    output logic [95:0]  core_data,
    output logic [31:0]  core_nonce,
    input  logic [511:0] core_hash,
    output logic         busy,
    output logic         done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_nonce,
    output logic [63:0]  res_hash_hi,
    output logic         overflow,
    input  logic         overflow_clr
);
    localparam int SLOT_W = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam int CNT_W  = $clog2(CORE_LATENCY + 1);

    sched_state_e          state_q, state_d;
    logic [511:0]          mid_q;
    logic [95:0]           data_q;
    logic [31:0]           cur_q;
    logic [31:0]           end_q;
    logic [63:0]           target_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [CORE_LATENCY-1:0] tag_v;
    logic [31:0]           tag_n [CORE_LATENCY];
    logic [CNT_W-1:0]      inflight_q;

    logic        accept, kill, issue, last_slot, retire, match, drain_empty;
    logic [63:0] hash_hi;
    logic        unused_hash_lo;
    logic        res_full, res_empty;
    res_rec_t    push_rec, res_head;

    assign hash_hi        = core_hash[HASH_HI_MSB:HASH_HI_LSB];
    assign unused_hash_lo = ^core_hash[HASH_HI_LSB-1:0];

    assign accept      = (state_q == ST_IDLE) && job_valid;
    assign kill        = abort && (state_q != ST_IDLE);
    assign last_slot   = (slot_q == SLOT_W'(ISSUE_INTERVAL - 1));
    assign issue       = (state_q == ST_RUN) && (slot_q == '0) && !kill;
    assign retire      = tag_v[CORE_LATENCY-1];
    assign match       = retire && !kill && (hash_hi <= target_q);
    // The last in-flight hash may be retiring this very cycle, so DRAIN can
    // finish together with it rather than one cycle later.
    assign drain_empty = (inflight_q == CNT_W'(retire));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:  if (job_valid) state_d = ST_RUN;
            ST_RUN: begin
                if (kill)                              state_d = ST_IDLE;
                else if (last_slot && cur_q == end_q)  state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (drain_empty) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign job_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_q    <= '0;
            data_q   <= '0;
            cur_q    <= '0;
            end_q    <= '0;
            target_q <= '0;
            slot_q   <= '0;
        end else if (accept) begin
            mid_q    <= job_midstate;
            data_q   <= job_data;
            cur_q    <= job_nonce_start;
            end_q    <= job_nonce_end;
            target_q <= job_target;
            slot_q   <= '0;
        end else if (state_q == ST_RUN && !kill) begin
            if (last_slot) begin
                slot_q <= '0;
                // Plain 32-bit increment gives the 0xFFFFFFFF -> 0 wrap.
                if (cur_q != end_q) cur_q <= cur_q + 32'd1;
            end else begin
                slot_q <= slot_q + 1'b1;
            end
        end
    end

    assign core_midstate = mid_q;
    assign core_data     = data_q;
    assign core_nonce    = cur_q;

    // Tag pipe: index 0 is the head, CORE_LATENCY-1 lines up with core_hash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tag_v <= '0;
        else if (kill) tag_v <= '0;
        else           tag_v <= {tag_v[CORE_LATENCY-2:0], issue};
    end

    always_ff @(posedge clk) begin
        tag_n[0] <= cur_q;
        for (int i = 1; i < CORE_LATENCY; i++) tag_n[i] <= tag_n[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    inflight_q <= '0;
        else if (kill) inflight_q <= '0;
        else begin
            case ({issue, retire})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign push_rec = '{nonce: tag_n[CORE_LATENCY-1], hash_hi: hash_hi};

    skein_result_fifo #(
        .DEPTH (RES_DEPTH),
        .W     ($bits(res_rec_t))
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (match),
        .pop   (res_ready),
        .din   (push_rec),
        .dout  (res_head),
        .full  (res_full),
        .empty (res_empty)
    );

    assign res_valid   = ~res_empty;
    assign res_nonce   = res_head.nonce;
    assign res_hash_hi = res_head.hash_hi;

    // A full FIFO only drops the match when no pop frees a slot this cycle;
    // a fresh drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          overflow <= 1'b0;
        else if (match && res_full && !res_ready) overflow <= 1'b1;
        else if (overflow_clr)               overflow <= 1'b0;
    end

endmodule
